// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, execute resolution and counter signals of the branch predictor
interface branch_predictor_if #(
    parameter int XLEN = 32,
    parameter int IDX  = 6
);
    logic [XLEN-1:0] f_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [IDX-1:0]  pred_idx;
    logic            ex_branch;
    logic [XLEN-1:0] ex_pc;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic [IDX-1:0]  ex_idx;
    logic            mispredict;
    logic [31:0]     br_count;
    logic [31:0]     mp_count;

    modport master (
        output f_pc, ex_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target, ex_idx,
        input  pred_taken, pred_target, pred_idx, mispredict, br_count, mp_count
    );

    modport slave (
        input  f_pc, ex_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target, ex_idx,
        output pred_taken, pred_target, pred_idx, mispredict, br_count, mp_count
    );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit PHT + direct-mapped BTB predictor; BP_GSHARE_EN selects gshare indexing
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int GHR_BITS = 6
) (
    input logic            clk,
    input logic            rst_n,
    branch_predictor_if.slave bus
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic [1:0]      pht        [ENTRIES];
    logic            btb_valid  [ENTRIES];
    logic [TAGW-1:0] btb_tag    [ENTRIES];
    logic [XLEN-1:0] btb_target [ENTRIES];
    logic [31:0]     br_count;
    logic [31:0]     mp_count;

    logic [IDX-1:0]  f_bidx;
    logic [TAGW-1:0] f_tag;
    logic [IDX-1:0]  f_pidx;
    logic            f_hit;
    logic            f_taken;
    logic [IDX-1:0]  ex_bidx;
    logic [TAGW-1:0] ex_tag;
    logic            mispredict_c;

    assign f_bidx  = bus.f_pc[IDX+1:2];
    assign f_tag   = bus.f_pc[XLEN-1:IDX+2];
    assign ex_bidx = bus.ex_pc[IDX+1:2];
    assign ex_tag  = bus.ex_pc[XLEN-1:IDX+2];

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] ghr_next;
    logic [IDX-1:0]      ghr_ext;

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_BITS-1:0] = ghr;
        ghr_next = ghr << 1;
        ghr_next[0] = bus.ex_taken;
    end

    assign f_pidx = f_bidx ^ ghr_ext;

    // History is trained only by resolved branches, so it never needs repair on a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (bus.ex_branch) begin
            ghr <= ghr_next;
        end
    end
`else
    assign f_pidx = f_bidx;
`endif

    assign f_hit   = btb_valid[f_bidx] && (btb_tag[f_bidx] == f_tag);
    assign f_taken = f_hit && pht[f_pidx][1];

    assign bus.pred_idx    = f_pidx;
    assign bus.pred_taken  = f_taken;
    assign bus.pred_target = f_taken ? btb_target[f_bidx] : bus.f_pc + XLEN'(4);

    assign mispredict_c = bus.ex_branch &&
                          ((bus.ex_taken != bus.ex_pred_taken) ||
                           (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
    assign bus.mispredict = mispredict_c;
    assign bus.br_count   = br_count;
    assign bus.mp_count   = mp_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i]       <= 2'b01;
                btb_valid[i] <= 1'b0;
            end
            br_count <= '0;
            mp_count <= '0;
        end else if (bus.ex_branch) begin
            if (bus.ex_taken) begin
                if (pht[bus.ex_idx] != 2'b11) begin
                    pht[bus.ex_idx] <= pht[bus.ex_idx] + 2'd1;
                end
                btb_valid[ex_bidx] <= 1'b1;
            end else if (pht[bus.ex_idx] != 2'b00) begin
                pht[bus.ex_idx] <= pht[bus.ex_idx] - 2'd1;
            end
            br_count <= br_count + 32'd1;
            if (mispredict_c) begin
                mp_count <= mp_count + 32'd1;
            end
        end
    end

    // Tag and target are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (bus.ex_branch && bus.ex_taken) begin
            btb_tag[ex_bidx]    <= ex_tag;
            btb_target[ex_bidx] <= bus.ex_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor (bimodal build)
module tb_branch_predictor;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    branch_predictor_if #(.XLEN(32), .IDX(6)) bif ();

    branch_predictor #(.XLEN(32), .ENTRIES(64), .GHR_BITS(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_branch(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                              input logic ptaken, input logic [31:0] ptarget);
        bif.ex_branch      = 1'b1;
        bif.ex_pc          = pc;
        bif.ex_taken       = taken;
        bif.ex_target      = target;
        bif.ex_pred_taken  = ptaken;
        bif.ex_pred_target = ptarget;
        bif.ex_idx         = pc[7:2];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bif.f_pc = 32'h100;
        bif.ex_branch = 1'b0;
        bif.ex_pc = '0; bif.ex_taken = 1'b0; bif.ex_target = '0;
        bif.ex_pred_taken = 1'b0; bif.ex_pred_target = '0; bif.ex_idx = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        if (bif.pred_taken !== 1'b0) $display("FAIL reset_pred_taken got %0h want 0", bif.pred_taken); else passed++;
        total++;
        if (bif.pred_target !== 32'h104) $display("FAIL reset_pred_target got %0h want 104", bif.pred_target); else passed++;
        total++;
        if (bif.br_count !== 32'd0 || bif.mp_count !== 32'd0)
            $display("FAIL reset_counts got br=%0d mp=%0d want 0 0", bif.br_count, bif.mp_count);
        else passed++;
        total++;
        if (bif.pred_idx !== 6'd0) $display("FAIL reset_pred_idx got %0d want 0", bif.pred_idx); else passed++;
        total++;
    endtask

    task automatic test_first_taken();
        bif.f_pc = 32'h100;
        set_branch(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        if (bif.mispredict !== 1'b1) $display("FAIL first_mispredict got %0b want 1", bif.mispredict); else passed++;
        total++;
        if (bif.pred_taken !== 1'b0) $display("FAIL no_bypass got %0b want 0", bif.pred_taken); else passed++;
        total++;
        step();
        bif.ex_branch = 1'b0;
        #1;
        if (bif.mp_count !== 32'd1 || bif.br_count !== 32'd1)
            $display("FAIL first_counts got br=%0d mp=%0d want 1 1", bif.br_count, bif.mp_count);
        else passed++;
        total++;
        if (bif.pred_taken !== 1'b1 || bif.pred_target !== 32'h80)
            $display("FAIL first_predict got taken=%0b tgt=%0h want 1 80", bif.pred_taken, bif.pred_target);
        else passed++;
        total++;
    endtask

    task automatic test_saturate();
        bif.f_pc = 32'h100;
        set_branch(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        if (bif.mispredict !== 1'b0) $display("FAIL correct_no_mispredict got %0b want 0", bif.mispredict); else passed++;
        total++;
        for (int i = 0; i < 4; i++) step();
        set_branch(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        if (bif.mispredict !== 1'b1) $display("FAIL nt_mispredict got %0b want 1", bif.mispredict); else passed++;
        total++;
        step();
        bif.ex_branch = 1'b0;
        #1;
        if (bif.pred_taken !== 1'b1) $display("FAIL sat_one_nt got %0b want 1", bif.pred_taken); else passed++;
        total++;
        set_branch(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        step();
        bif.ex_branch = 1'b0;
        #1;
        if (bif.pred_taken !== 1'b0 || bif.pred_target !== 32'h104)
            $display("FAIL sat_two_nt got taken=%0b tgt=%0h want 0 104", bif.pred_taken, bif.pred_target);
        else passed++;
        total++;
        if (bif.br_count !== 32'd7 || bif.mp_count !== 32'd3)
            $display("FAIL sat_counts got br=%0d mp=%0d want 7 3", bif.br_count, bif.mp_count);
        else passed++;
        total++;
    endtask

    task automatic test_alias();
        set_branch(32'h200, 1'b1, 32'h40, 1'b0, 32'h204);
        step();
        bif.ex_branch = 1'b0;
        bif.f_pc = 32'h100;
        #1;
        if (bif.pred_taken !== 1'b0 || bif.pred_target !== 32'h104)
            $display("FAIL alias_old_miss got taken=%0b tgt=%0h want 0 104", bif.pred_taken, bif.pred_target);
        else passed++;
        total++;
        bif.f_pc = 32'h200;
        #1;
        if (bif.pred_taken !== 1'b1 || bif.pred_target !== 32'h40)
            $display("FAIL alias_new_hit got taken=%0b tgt=%0h want 1 40", bif.pred_taken, bif.pred_target);
        else passed++;
        total++;
    endtask

    task automatic test_wrong_target();
        set_branch(32'h104, 1'b1, 32'h80, 1'b0, 32'h108);
        step();
        set_branch(32'h104, 1'b1, 32'h90, 1'b1, 32'h80);
        #1;
        if (bif.mispredict !== 1'b1) $display("FAIL target_mispredict got %0b want 1", bif.mispredict); else passed++;
        total++;
        step();
        bif.ex_branch = 1'b0;
        bif.f_pc = 32'h104;
        #1;
        if (bif.pred_taken !== 1'b1 || bif.pred_target !== 32'h90)
            $display("FAIL target_update got taken=%0b tgt=%0h want 1 90", bif.pred_taken, bif.pred_target);
        else passed++;
        total++;
        set_branch(32'h108, 1'b0, 32'h300, 1'b0, 32'h10c);
        #1;
        if (bif.mispredict !== 1'b0) $display("FAIL nt_correct got %0b want 0", bif.mispredict); else passed++;
        total++;
        step();
        bif.ex_branch = 1'b0;
        bif.ex_taken = 1'b1;
        bif.f_pc = 32'h108;
        step(); step();
        if (bif.pred_taken !== 1'b0 || bif.pred_target !== 32'h10c)
            $display("FAIL nt_no_btb got taken=%0b tgt=%0h want 0 10c", bif.pred_taken, bif.pred_target);
        else passed++;
        total++;
        if (bif.br_count !== 32'd11 || bif.mp_count !== 32'd6)
            $display("FAIL idle_counts got br=%0d mp=%0d want 11 6", bif.br_count, bif.mp_count);
        else passed++;
        total++;
    endtask

    task automatic test_back_to_back();
        bif.f_pc = 32'h10c;
        set_branch(32'h10c, 1'b1, 32'h60, 1'b1, 32'h60);
        step(); step(); step();
        set_branch(32'h10c, 1'b0, 32'h0, 1'b1, 32'h60);
        step();
        bif.ex_branch = 1'b0;
        #1;
        if (bif.pred_taken !== 1'b1 || bif.pred_target !== 32'h60)
            $display("FAIL b2b_predict got taken=%0b tgt=%0h want 1 60", bif.pred_taken, bif.pred_target);
        else passed++;
        total++;
        if (bif.br_count !== 32'd15 || bif.mp_count !== 32'd7)
            $display("FAIL b2b_counts got br=%0d mp=%0d want 15 7", bif.br_count, bif.mp_count);
        else passed++;
        total++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bif.f_pc = 32'h200;
        #1;
        if (bif.pred_taken !== 1'b0 || bif.pred_target !== 32'h204)
            $display("FAIL rst_mid_200 got taken=%0b tgt=%0h want 0 204", bif.pred_taken, bif.pred_target);
        else passed++;
        total++;
        bif.f_pc = 32'h104;
        #1;
        if (bif.pred_taken !== 1'b0 || bif.pred_target !== 32'h108)
            $display("FAIL rst_mid_104 got taken=%0b tgt=%0h want 0 108", bif.pred_taken, bif.pred_target);
        else passed++;
        total++;
        if (bif.br_count !== 32'd0 || bif.mp_count !== 32'd0)
            $display("FAIL rst_mid_counts got br=%0d mp=%0d want 0 0", bif.br_count, bif.mp_count);
        else passed++;
        total++;
        set_branch(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        if (bif.mispredict !== 1'b1) $display("FAIL rst_mispredict_comb got %0b want 1", bif.mispredict); else passed++;
        total++;
        bif.ex_branch = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bif.f_pc = 32'h10c;
        #1;
        if (bif.pred_taken !== 1'b0 || bif.br_count !== 32'd0)
            $display("FAIL rst_release got taken=%0b br=%0d want 0 0", bif.pred_taken, bif.br_count);
        else passed++;
        total++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_first_taken();
        test_saturate();
        test_alias();
        test_wrong_target();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the fetch stage; the predicting counterpart of the execute-stage branch-resolution logic. Fetch looks up a PC and gets a same-cycle taken/target prediction. Execute returns each resolved conditional branch (taken flag, actual target, prediction it carried), which trains a 2-bit saturating-counter pattern history table (PHT) and a direct-mapped branch target buffer (BTB) and raises a same-cycle `mispredict` for the pipeline flush.

## Interface
- `XLEN`, 32, PC/target width
- `ENTRIES`, 64, PHT and BTB depth; power of two, ≥4
- `GHR_BITS`, 6, global history length; 1..log2(ENTRIES), used only with gshare

Ports (`IDX = log2(ENTRIES)`):
- `clk` in 1: the single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `f_pc` in XLEN: fetch PC; bits [1:0] ignored
- `pred_taken` out 1: predict taken
- `pred_target` out XLEN: predicted target; `f_pc + 4` when `pred_taken` = 0
- `pred_idx` out IDX: PHT index used; carried down the pipeline
- `ex_branch` in 1: a conditional branch resolved this cycle
- `ex_pc` in XLEN: PC of the resolved branch
- `ex_taken` in 1: actual outcome
- `ex_target` in XLEN: actual taken target
- `ex_pred_taken` in 1: `pred_taken` carried with the branch
- `ex_pred_target` in XLEN: `pred_target` carried with the branch
- `ex_idx` in IDX: `pred_idx` carried with the branch
- `mispredict` out 1: flush request
- `br_count` out 32: resolved-branch count
- `mp_count` out 32: misprediction count

## Operation
- PHT: ENTRIES × 2-bit counters. 00/01 predict not-taken; 10/11 predict taken.
- BTB: ENTRIES × {valid, tag = pc[XLEN-1:IDX+2], target}, indexed by pc[IDX+1:2].
- Lookup is combinational:
  - `pred_idx` = PHT index of `f_pc`.
  - `hit` = BTB valid && tag match.
  - `pred_taken` = `hit` && PHT[pred_idx][1].
  - `pred_target` = BTB target if `pred_taken`, else `f_pc + 4`, mod 2^XLEN.
- Update on a clock edge with `ex_branch` = 1:
  - PHT[ex_idx] increments if `ex_taken`, else decrements; saturates at 11 and 00.
  - If `ex_taken`, the BTB entry for `ex_pc` is written: valid = 1, tag, target = `ex_target`. This replaces any other tag at that entry. Not-taken branches never write the BTB.
  - `br_count` increments; `mp_count` increments when `mispredict`. Both wrap at 2^32.
- `mispredict` = `ex_branch` && ((`ex_taken` != `ex_pred_taken`) || (`ex_taken` && `ex_target` != `ex_pred_target`)).
- All update state is ignored when `ex_branch` = 0.

## Timing
- Lookup latency 0: predictions are combinational from `f_pc` and current state.
- `mispredict` is combinational, same cycle as `ex_branch`.
- Updates are visible to lookups from the next cycle. A same-cycle lookup of an entry being written returns the old value; there is no bypass.
- Reset (asynchronous, any time, including mid-stream):
  - All PHT counters go to 01 and all BTB valid bits go to 0.
  - GHR, `br_count` and `mp_count` go to 0.
  - Outputs then read `pred_taken` = 0, `pred_target` = `f_pc + 4`, `mispredict` follows its inputs.
  - Reset does not gate the combinational `mispredict`; the pipeline holds `ex_branch` low during reset.
- Back-to-back resolutions to the same entry, one per cycle, each apply in order.

## Configuration
- `BP_GSHARE_EN` defined:
  - PHT index = pc[IDX+1:2] XOR {zero-extend GHR}.
  - GHR updates on each `ex_branch` edge to {GHR[GHR_BITS-2:0], ex_taken}. The update is non-speculative, and training uses `ex_idx` so the index matches prediction time.
- `BP_GSHARE_EN` undefined:
  - PHT index = pc[IDX+1:2]. No GHR register exists.
  - `ex_idx` is still used for update and equals the bimodal index.

## Test plan
- Reset, then `f_pc`=0x100 → `pred_taken`=0, `pred_target`=0x104, counts 0.
- Resolve `ex_pc`=0x100, taken, target 0x80, predicted not-taken → `mispredict`=1 that cycle, `mp_count`=1. Next cycle `f_pc`=0x100 gives `pred_taken`=1, target 0x80 (counter 10).
- Resolve 0x100 taken ×4 then not-taken ×1 → counter 11→10, still predicts taken. A second not-taken gives 01, predicting not-taken.
- Alias: with ENTRIES=64, a taken branch at 0x100 to 0x80, then a taken branch at 0x200 to 0x40 (same BTB index, different tag) → lookup 0x100 misses (`pred_taken`=0). Lookup 0x200 hits only if its counter ≥10.
- Correct taken direction with wrong target (`ex_pred_target`=0x80, `ex_target`=0x90) → `mispredict`=1; the BTB is updated to 0x90.
- Assert `rst_n` low mid-stream after training → all predictions not-taken immediately. With `BP_GSHARE_EN`, the same PC predicts differently under GHR histories 000000 and 000001 once trained.
